// File: rtl/booth_pkg.sv
// Shared encodings for the sequential Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth op-codes, indexed by {Q[0], Q-1}
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Combinational (WIDTH+1)-bit add/subtract; carry-out is dropped.
module booth_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode and a
// start / valid-ready handshake. Operands are widened by one bit so both
// modes run the same signed algorithm for WIDTH+1 steps.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int E     = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);

  state_t           state;
  logic [E-1:0]     a;
  logic [E-1:0]     q;
  logic [E-1:0]     m;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       op;
  logic [E-1:0]     sum;
  logic [E-1:0]     a_nxt;

  // Sign- or zero-extend an operand to the internal width
  function automatic logic [E-1:0] ext(input logic sgn, input logic [WIDTH-1:0] v);
    ext = {sgn & v[WIDTH-1], v};
  endfunction

  assign op = {q[0], q_m1};

  booth_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (a),
    .b   (m),
    .sub (op == OP_SUB),
    .sum (sum)
  );

  // Accumulator value before the shift: add, subtract or keep
  always_comb begin
    a_nxt = a;
    case (op)
      OP_ADD, OP_SUB: a_nxt = sum;
      OP_NOP:         a_nxt = a;
      default:        a_nxt = a;
    endcase
  end

  // Control FSM plus datapath registers; all outputs registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            m      <= ext(i_signed, i_multiplicand);
            q      <= ext(i_signed, i_multiplier);
            a      <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          // arithmetic right shift of {A, Q, Q-1}
          a    <= {a_nxt[E-1], a_nxt[E-1:1]};
          q    <= {a_nxt[0], q[E-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(E - 1)) begin
            // low 2*WIDTH bits of the shifted {A, Q}
            o_product <= {a_nxt[WIDTH-1:0], q[E-1:1]};
            o_valid   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
